// File: rtl/skolem_sweep_ctrl.sv
// -----------------------------------------------------------------------------
// skolem_sweep_ctrl
//
// Purpose:
//   Exhaustive-check sequencer for small combinational Skolem-function units.
//   It steps through every N-bit input assignment on a shared stimulus bus.
//   After each step it waits SETTLE cycles. It then compares the candidate
//   response with the golden-model response for the same vector and keeps
//   running mismatch statistics.
//
// Parameters:
//   N       stimulus width; the sweep covers 2^N vectors (1..16)
//   SETTLE  cycles between driving vec_o and sampling the responses (0..15)
//
// Ports:
//   clk               rising-edge clock
//   rst               asynchronous, active-high reset
//   start             begin a sweep (honoured only in IDLE or DONE)
//   abort             terminate an active sweep
//   stop_on_fail      captured at start; 1 = end the sweep at the first mismatch
//   vec_o     [N-1:0] current stimulus to both evaluators
//   resp_i            candidate Skolem unit output
//   golden_i          golden-model output for vec_o
//   busy              sweep in progress
//   done              sweep finished (complete or stopped on fail), level
//   pass              valid while done=1: no mismatches were seen
//   err_cnt   [N:0]   mismatch count (max 2^N, so it never overflows)
//   first_fail_vec    vector of the first mismatch
//   first_fail_valid  first_fail_vec holds a captured mismatch
// -----------------------------------------------------------------------------
module skolem_sweep_ctrl #(
   parameter int unsigned N      = 8,
   parameter int unsigned SETTLE = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic         abort,
   input  logic         stop_on_fail,
   output logic [N-1:0] vec_o,
   input  logic         resp_i,
   input  logic         golden_i,
   output logic         busy,
   output logic         done,
   output logic         pass,
   output logic [N:0]   err_cnt,
   output logic [N-1:0] first_fail_vec,
   output logic         first_fail_valid
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT,
      ST_CHECK,
      ST_DONE
   } state_t;

   // Last value of the settle counter before moving on to CHECK. With
   // SETTLE=0 the WAIT state is never entered and the value is unused.
   localparam logic [3:0]   LP_SETTLE_LAST = (SETTLE > 0) ? 4'(SETTLE - 1) : 4'd0;
   localparam logic [N-1:0] LP_VEC_LAST    = {N{1'b1}};
   localparam logic [N-1:0] LP_VEC_ONE     = {{(N-1){1'b0}}, 1'b1};
   localparam logic [N:0]   LP_ERR_ONE     = {{N{1'b0}}, 1'b1};
   // State that starts each vector: settle first, or sample straight away.
   localparam state_t       LP_VEC_ENTRY   = (SETTLE > 0) ? ST_WAIT : ST_CHECK;

   state_t       r_state;
   state_t       w_next_state;
   logic [3:0]   r_settle_cnt;
   logic [N-1:0] r_vec;
   logic [N:0]   r_err_cnt;
   logic [N-1:0] r_ff_vec;
   logic         r_ff_valid;
   logic         r_stop;
   logic         r_pass;

   logic         w_mismatch;
   logic         w_vec_last;
   logic         w_settle_last;
   logic         w_load;
   logic         w_abort;
   logic         w_do_check;
   logic         w_finish;

   assign w_mismatch    = resp_i ^ golden_i;
   assign w_vec_last    = (r_vec == LP_VEC_LAST);
   assign w_settle_last = (r_settle_cnt == LP_SETTLE_LAST);

   // -------------------------------------------------------------------------
   // State register
   // -------------------------------------------------------------------------
   // NOTE: sequential state is assigned with <= so that every register
   // samples the values from before the edge, whatever the statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // -------------------------------------------------------------------------
   // Next-state and control decode
   // -------------------------------------------------------------------------
   // NOTE: every output of this block gets a default first. Otherwise a path
   // that leaves a signal unassigned would infer a latch.
   always_comb begin
      w_next_state = r_state;
      w_load       = 1'b0;
      w_abort      = 1'b0;
      w_do_check   = 1'b0;
      w_finish     = 1'b0;

      unique case (r_state)
         ST_IDLE, ST_DONE: begin
            // start beats a simultaneous abort here; abort alone is ignored.
            if (start) begin
               w_load       = 1'b1;
               w_next_state = LP_VEC_ENTRY;
            end
         end

         ST_WAIT: begin
            if (abort) begin
               w_abort      = 1'b1;
               w_next_state = ST_IDLE;
            end else if (w_settle_last) begin
               w_next_state = ST_CHECK;
            end
         end

         ST_CHECK: begin
            // abort wins over the sample, so the partial results hold.
            if (abort) begin
               w_abort      = 1'b1;
               w_next_state = ST_IDLE;
            end else begin
               w_do_check = 1'b1;
               if (w_vec_last || (w_mismatch && r_stop)) begin
                  w_finish     = 1'b1;
                  w_next_state = ST_DONE;
               end else begin
                  w_next_state = LP_VEC_ENTRY;
               end
            end
         end

         default: begin
            w_next_state = ST_IDLE;
         end
      endcase
   end

   // -------------------------------------------------------------------------
   // Settle counter: runs only while staying in WAIT and clears on exit, so
   // each visit to WAIT lasts exactly SETTLE cycles.
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_settle_cnt <= 4'd0;
      end else if ((r_state == ST_WAIT) && !abort && !w_settle_last) begin
         r_settle_cnt <= r_settle_cnt + 4'd1;
      end else begin
         r_settle_cnt <= 4'd0;
      end
   end

   // -------------------------------------------------------------------------
   // Sweep datapath: stimulus vector, mismatch statistics, verdict
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_vec      <= '0;
         r_err_cnt  <= '0;
         r_ff_vec   <= '0;
         r_ff_valid <= 1'b0;
         r_stop     <= 1'b0;
         r_pass     <= 1'b0;
      end else if (w_load) begin
         r_vec      <= '0;
         r_err_cnt  <= '0;
         r_ff_vec   <= '0;
         r_ff_valid <= 1'b0;
         r_stop     <= stop_on_fail;
         r_pass     <= 1'b0;
      end else if (w_abort) begin
         // vec_o and the statistics keep their partial values.
         r_pass <= 1'b0;
      end else if (w_do_check) begin
         if (w_mismatch) begin
            r_err_cnt <= r_err_cnt + LP_ERR_ONE;
            if (!r_ff_valid) begin
               r_ff_vec   <= r_vec;
               r_ff_valid <= 1'b1;
            end
         end
         if (w_finish) begin
            // The verdict must include this cycle's sample, which has not
            // reached r_err_cnt yet.
            r_pass <= (r_err_cnt == '0) && !w_mismatch;
         end else begin
            // The terminal vector always finishes, so vec_o never wraps.
            r_vec <= r_vec + LP_VEC_ONE;
         end
      end
   end

   // -------------------------------------------------------------------------
   // Outputs
   // -------------------------------------------------------------------------
   // busy/done are decoded from the state register. They drop together with
   // the state when reset is asserted, with no clock edge needed.
   assign busy             = (r_state == ST_WAIT) || (r_state == ST_CHECK);
   assign done             = (r_state == ST_DONE);
   assign pass             = r_pass;
   assign vec_o            = r_vec;
   assign err_cnt          = r_err_cnt;
   assign first_fail_vec   = r_ff_vec;
   assign first_fail_valid = r_ff_valid;

endmodule

// File: tb/tb_skolem_sweep_ctrl.sv
module tb_skolem_sweep_ctrl;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   // ---------------- DUT with defaults: N=8, SETTLE=1 ----------------
   logic       s8_start, s8_abort, s8_stop;
   logic [7:0] s8_vec;
   logic       s8_resp, s8_golden;
   logic       s8_busy, s8_done, s8_pass;
   logic [8:0] s8_err;
   logic [7:0] s8_ffv;
   logic       s8_ffval;
   bit         fault8 [256];

   assign s8_golden = s8_vec[7] ^ (s8_vec[2] & s8_vec[1]);
   assign s8_resp   = s8_golden ^ fault8[s8_vec];

   skolem_sweep_ctrl #(.N(8), .SETTLE(1)) u_dut8 (
      .clk(clk), .rst(rst), .start(s8_start), .abort(s8_abort),
      .stop_on_fail(s8_stop), .vec_o(s8_vec), .resp_i(s8_resp),
      .golden_i(s8_golden), .busy(s8_busy), .done(s8_done), .pass(s8_pass),
      .err_cnt(s8_err), .first_fail_vec(s8_ffv), .first_fail_valid(s8_ffval)
   );

   // ---------------- DUT with N=4, SETTLE=0 ----------------
   logic       s4_start, s4_abort, s4_stop;
   logic [3:0] s4_vec;
   logic       s4_resp, s4_golden;
   logic       s4_busy, s4_done, s4_pass;
   logic [4:0] s4_err;
   logic [3:0] s4_ffv;
   logic       s4_ffval;
   bit         fault4 [16];

   assign s4_golden = s4_vec[3] | s4_vec[0];
   assign s4_resp   = s4_golden ^ fault4[s4_vec];

   skolem_sweep_ctrl #(.N(4), .SETTLE(0)) u_dut4 (
      .clk(clk), .rst(rst), .start(s4_start), .abort(s4_abort),
      .stop_on_fail(s4_stop), .vec_o(s4_vec), .resp_i(s4_resp),
      .golden_i(s4_golden), .busy(s4_busy), .done(s4_done), .pass(s4_pass),
      .err_cnt(s4_err), .first_fail_vec(s4_ffv), .first_fail_valid(s4_ffval)
   );

   // Selected-DUT view used by the generic sweep task.
   bit          sel4;
   logic        c_busy, c_done, c_pass, c_ffval;
   logic [31:0] c_vec, c_err, c_ffv;

   always_comb begin
      c_busy  = sel4 ? s4_busy  : s8_busy;
      c_done  = sel4 ? s4_done  : s8_done;
      c_pass  = sel4 ? s4_pass  : s8_pass;
      c_ffval = sel4 ? s4_ffval : s8_ffval;
      c_vec   = sel4 ? 32'(s4_vec) : 32'(s8_vec);
      c_err   = sel4 ? 32'(s4_err) : 32'(s8_err);
      c_ffv   = sel4 ? 32'(s4_ffv) : 32'(s8_ffv);
   end

   // Scoreboard of expected sweep outcomes.
   typedef struct {
      int cycles;
      int err;
      int ffv;
      bit ffval;
      bit pass;
      int vec;
   } exp_t;

   exp_t sb_q [$];
   int   n_pass  = 0;
   int   n_total = 0;

   // Reference model: walk the vectors in order against the fault map.
   function automatic exp_t predict(input bit use4, input bit stop);
      exp_t e;
      int   last  = use4 ? 15 : 255;
      int   per   = use4 ? 1 : 2;
      int   n     = 0;
      bit   ended = 1'b0;
      bit   f;
      e.err = 0; e.ffv = 0; e.ffval = 1'b0; e.vec = 0;
      for (int v = 0; v <= last; v++) begin
         if (!ended) begin
            f = use4 ? fault4[v] : fault8[v];
            if (f) begin
               e.err++;
               if (!e.ffval) begin
                  e.ffval = 1'b1;
                  e.ffv   = v;
               end
            end
            e.vec = v;
            n     = v + 1;
            if (f && stop) ended = 1'b1;
         end
      end
      e.cycles = n * per;
      e.pass   = (e.err == 0);
      return e;
   endfunction

   task automatic clear_faults();
      for (int i = 0; i < 256; i++) fault8[i] = 1'b0;
      for (int i = 0; i < 16; i++)  fault4[i] = 1'b0;
   endtask

   // One-cycle start pulse. Returns at the first negedge after busy rises.
   task automatic drive_start(input bit use4, input bit stop, input bit with_abort);
      @(negedge clk);
      if (use4) begin
         s4_start = 1'b1; s4_stop = stop; s4_abort = with_abort;
      end else begin
         s8_start = 1'b1; s8_stop = stop; s8_abort = with_abort;
      end
      @(negedge clk);
      s4_start = 1'b0; s4_abort = 1'b0;
      s8_start = 1'b0; s8_abort = 1'b0;
   endtask

   // Full sweep on the selected DUT, with a per-cycle vec_o check and a
   // scoreboard comparison once done rises.
   task automatic run_sweep(input bit use4, input bit stop, input bit with_abort,
                            input string name);
      exp_t e;
      int   cyc = 0;
      int   exp_vec;
      sel4 = use4;
      sb_q.push_back(predict(use4, stop));
      drive_start(use4, stop, with_abort);

      n_total++;
      if (c_busy !== 1'b1) $display("FAIL %s busy_rise: got %b expected 1", name, c_busy);
      else n_pass++;

      while (!c_done && cyc < 2000) begin
         exp_vec = use4 ? cyc : cyc / 2;
         n_total++;
         if (c_vec !== 32'(exp_vec))
            $display("FAIL %s vec_step@%0d: got %0d expected %0d", name, cyc, c_vec, exp_vec);
         else n_pass++;
         @(negedge clk);
         cyc++;
      end

      e = sb_q.pop_front();
      n_total++;
      if (c_done !== 1'b1) $display("FAIL %s done_timeout: got %b expected 1", name, c_done);
      else n_pass++;
      n_total++;
      if (cyc != e.cycles) $display("FAIL %s cycles: got %0d expected %0d", name, cyc, e.cycles);
      else n_pass++;
      n_total++;
      if (c_busy !== 1'b0) $display("FAIL %s busy_end: got %b expected 0", name, c_busy);
      else n_pass++;
      n_total++;
      if (c_err !== 32'(e.err)) $display("FAIL %s err_cnt: got %0d expected %0d", name, c_err, e.err);
      else n_pass++;
      n_total++;
      if (c_ffval !== e.ffval) $display("FAIL %s ff_valid: got %b expected %b", name, c_ffval, e.ffval);
      else n_pass++;
      n_total++;
      if (c_ffv !== 32'(e.ffv)) $display("FAIL %s ff_vec: got %0h expected %0h", name, c_ffv, e.ffv);
      else n_pass++;
      n_total++;
      if (c_pass !== e.pass) $display("FAIL %s pass: got %b expected %b", name, c_pass, e.pass);
      else n_pass++;
      n_total++;
      if (c_vec !== 32'(e.vec)) $display("FAIL %s vec_end: got %0h expected %0h", name, c_vec, e.vec);
      else n_pass++;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      n_total++;
      if ({s8_vec, s8_busy, s8_done, s8_pass, s8_err, s8_ffv, s8_ffval} !== '0)
         $display("FAIL reset_d8: got %0h expected 0",
                  {s8_vec, s8_busy, s8_done, s8_pass, s8_err, s8_ffv, s8_ffval});
      else n_pass++;
      n_total++;
      if ({s4_vec, s4_busy, s4_done, s4_pass, s4_err, s4_ffv, s4_ffval} !== '0)
         $display("FAIL reset_d4: got %0h expected 0",
                  {s4_vec, s4_busy, s4_done, s4_pass, s4_err, s4_ffv, s4_ffval});
      else n_pass++;
      rst = 1'b0;
   endtask

   task automatic test_golden_tie();
      clear_faults();
      run_sweep(1'b0, 1'b0, 1'b0, "golden_tie");
      // Results stay put in DONE; a lone abort there is ignored.
      repeat (3) @(negedge clk);
      s8_abort = 1'b1;
      @(negedge clk);
      s8_abort = 1'b0;
      @(negedge clk);
      n_total++;
      if (s8_done !== 1'b1 || s8_pass !== 1'b1 || s8_err !== 9'd0)
         $display("FAIL done_hold: got done=%b pass=%b err=%0d expected 1 1 0",
                  s8_done, s8_pass, s8_err);
      else n_pass++;
   endtask

   task automatic test_single_fault();
      clear_faults();
      fault8[8'h5A] = 1'b1;
      // start arrives together with abort in DONE: start must win.
      run_sweep(1'b0, 1'b0, 1'b1, "single_fault");
   endtask

   task automatic test_stop_on_fail();
      clear_faults();
      fault8[8'h10] = 1'b1;
      fault8[8'h20] = 1'b1;
      run_sweep(1'b0, 1'b1, 1'b0, "stop_on_fail");
   endtask

   task automatic test_abort();
      clear_faults();
      fault8[8'h10] = 1'b1;
      fault8[8'h70] = 1'b1;
      sel4 = 1'b0;
      drive_start(1'b0, 1'b0, 1'b0);
      repeat (256) @(negedge clk);   // WAIT phase of vector 0x80
      n_total++;
      if (s8_vec !== 8'h80 || s8_busy !== 1'b1)
         $display("FAIL abort_pre: got vec=%0h busy=%b expected 80 1", s8_vec, s8_busy);
      else n_pass++;
      s8_abort = 1'b1;
      @(negedge clk);
      s8_abort = 1'b0;
      n_total++;
      if (s8_busy !== 1'b0 || s8_done !== 1'b0 || s8_pass !== 1'b0)
         $display("FAIL abort_flags: got busy=%b done=%b pass=%b expected 0 0 0",
                  s8_busy, s8_done, s8_pass);
      else n_pass++;
      n_total++;
      if (s8_vec !== 8'h80) $display("FAIL abort_vec_hold: got %0h expected 80", s8_vec);
      else n_pass++;
      n_total++;
      if (s8_err !== 9'd2 || s8_ffv !== 8'h10 || s8_ffval !== 1'b1)
         $display("FAIL abort_partial: got err=%0d ffv=%0h ffval=%b expected 2 10 1",
                  s8_err, s8_ffv, s8_ffval);
      else n_pass++;
      // Restart begins from vector 0 with cleared statistics.
      drive_start(1'b0, 1'b0, 1'b0);
      n_total++;
      if (s8_vec !== 8'h00 || s8_err !== 9'd0 || s8_ffval !== 1'b0 || s8_busy !== 1'b1)
         $display("FAIL abort_restart: got vec=%0h err=%0d ffval=%b busy=%b expected 0 0 0 1",
                  s8_vec, s8_err, s8_ffval, s8_busy);
      else n_pass++;
      s8_abort = 1'b1;
      @(negedge clk);
      s8_abort = 1'b0;
   endtask

   task automatic test_async_reset_and_busy_start();
      clear_faults();
      fault8[8'h05] = 1'b1;
      fault8[8'h20] = 1'b1;
      sel4 = 1'b0;
      drive_start(1'b0, 1'b0, 1'b0);
      for (int cyc = 0; cyc < 102; cyc++) begin
         n_total++;
         if (s8_vec !== 8'(cyc / 2))
            $display("FAIL busy_start_seq@%0d: got %0h expected %0h", cyc, s8_vec, cyc / 2);
         else n_pass++;
         s8_start = (cyc == 40);     // start while busy must be ignored
         @(negedge clk);
      end
      s8_start = 1'b0;
      n_total++;
      if (s8_vec !== 8'h33 || s8_err !== 9'd2)
         $display("FAIL pre_reset: got vec=%0h err=%0d expected 33 2", s8_vec, s8_err);
      else n_pass++;
      #2 rst = 1'b1;
      #1;                            // still well before the next rising edge
      n_total++;
      if ({s8_vec, s8_busy, s8_done, s8_pass, s8_err, s8_ffv, s8_ffval} !== '0)
         $display("FAIL async_reset: got %0h expected 0",
                  {s8_vec, s8_busy, s8_done, s8_pass, s8_err, s8_ffv, s8_ffval});
      else n_pass++;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_settle0_all_mismatch();
      clear_faults();
      for (int i = 0; i < 16; i++) fault4[i] = 1'b1;
      run_sweep(1'b1, 1'b0, 1'b0, "settle0_all_fail");
   endtask

   initial begin
      s8_start = 1'b0; s8_abort = 1'b0; s8_stop = 1'b0;
      s4_start = 1'b0; s4_abort = 1'b0; s4_stop = 1'b0;
      sel4 = 1'b0;
      clear_faults();

      test_reset();
      test_golden_tie();
      test_single_fault();
      test_stop_on_fail();
      test_abort();
      test_async_reset_and_busy_start();
      test_settle0_all_mismatch();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/skolem_sweep_ctrl.md
Name: skolem_sweep_ctrl

Overview:
Sequential exhaustive-check controller for small combinational Skolem-function units, such as the 8-input, 1-output invertibility-condition circuits. It enumerates every N-bit input assignment onto a shared stimulus bus and waits a programmable settle time. It then samples the unit-under-check response against a golden-model response and accumulates mismatch statistics. It sits between the regression harness (start/abort/result handshake) and a pair of combinational evaluators (candidate Skolem function and golden invertibility condition) driven by the same vector.

Parameters:
N, 8, stimulus vector width; the sweep covers 2^N vectors (N from 1 to 16).
SETTLE, 1, cycles between driving vec_o and sampling resp_i/golden_i (0 to 15; 0 = sample in the same cycle).

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
start  input  1  begin sweep; honoured only in IDLE or DONE
abort  input  1  terminate an active sweep
stop_on_fail  input  1  sampled at start; 1 = end sweep at first mismatch
vec_o  output  N  current stimulus to both evaluators
resp_i  input  1  candidate Skolem unit output
golden_i  input  1  golden-model output for vec_o
busy  output  1  sweep in progress
done  output  1  sweep completed normally, or stopped on fail; level signal
pass  output  1  valid when done=1: err_cnt == 0
err_cnt  output  N+1  mismatch count; cannot overflow (max 2^N)
first_fail_vec  output  N  vector of first mismatch
first_fail_valid  output  1  first_fail_vec holds a captured mismatch

Behaviour:
- Reset (async, any state): state=IDLE; vec_o=0, busy=0, done=0, pass=0, err_cnt=0, first_fail_vec=0, first_fail_valid=0, internal settle counter=0, latched stop flag=0.
- States: IDLE, WAIT, CHECK, DONE.
- IDLE/DONE + start=1:
  - vec_o←0, err_cnt←0, first_fail_valid←0, first_fail_vec←0, done←0, pass←0, latch stop_on_fail, busy←1.
  - Next state is WAIT if SETTLE>0, else CHECK.
- WAIT: settle counter counts 0..SETTLE-1, then goes to CHECK. The counter clears on leaving WAIT.
- CHECK (one cycle), on mismatch = resp_i ^ golden_i:
  - If mismatch: err_cnt+1; if first_fail_valid=0, first_fail_vec←vec_o and first_fail_valid←1.
  - If vec_o == 2^N-1, or mismatch with the latched stop flag set: go to DONE (busy←0, done←1, pass←(updated err_cnt==0)). vec_o holds.
  - Else: vec_o←vec_o+1 and return to WAIT (SETTLE>0) or stay in CHECK (SETTLE=0).
- Timing: each vector occupies SETTLE+1 cycles. A full sweep takes 2^N·(SETTLE+1) cycles from the first busy cycle to done rising. Defaults give 512 cycles.
- vec_o never wraps within a sweep. The terminal vector is checked exactly once.
- abort=1 while busy: next state IDLE, busy←0, done←0, pass←0. err_cnt and first_fail_* hold partial results, and vec_o holds.
- abort has priority over a CHECK completing in the same cycle. abort in IDLE/DONE is ignored.
- start while busy is ignored. start and abort together in IDLE/DONE: start wins.
- done/pass/results stay stable in DONE until the next start or reset.
- resp_i/golden_i are only sampled in CHECK; their values in other states are don't-care.

Test Plan:
- Golden tie: resp_i=golden_i for all vectors, N=8, SETTLE=1 → done rises exactly 512 cycles after busy rises; pass=1, err_cnt=0, first_fail_valid=0, vec_o=0xFF.
- Single fault: resp_i inverted only at vec 0x5A, stop_on_fail=0 → full sweep; err_cnt=1, first_fail_vec=0x5A, first_fail_valid=1, pass=0.
- Stop on fail: faults at 0x10 and 0x20, stop_on_fail=1 → done after vector 0x10 (34 cycles), err_cnt=1, first_fail_vec=0x10, vec_o=0x10.
- Abort: abort at vec 0x80 in WAIT → IDLE next cycle, busy=0, done=0. A new start restarts at vec 0 with err_cnt cleared.
- Async reset mid-sweep (vec 0x33, err_cnt=2) → all outputs 0 immediately, without waiting for a clock edge. start while busy is ignored (vec_o sequence unchanged).
- SETTLE=0, N=4, all-mismatch stimulus → vec_o advances every cycle; done after 16 cycles, err_cnt=16, first_fail_vec=0.
